// File: rtl/oam_dma_if.sv
// Bus bundle between the CPU datapath, the OAM DMA sequencer and cpu_memory.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic        cpu_r_en;
  logic [7:0]  cpu_w_data;
  logic [7:0]  mem_r_data;
  logic [15:0] mem_addr;
  logic        mem_r_en;
  logic [7:0]  mem_w_data;
  logic        cpu_stall;
  logic        dma_active;
  logic        dma_done;

  // Driver side: CPU datapath and memory model feeding the sequencer.
  modport master (
    output cpu_addr, cpu_r_en, cpu_w_data, mem_r_data,
    input  mem_addr, mem_r_en, mem_w_data, cpu_stall, dma_active, dma_done
  );

  // Sequencer side.
  modport slave (
    input  cpu_addr, cpu_r_en, cpu_w_data, mem_r_data,
    output mem_addr, mem_r_en, mem_w_data, cpu_stall, dma_active, dma_done
  );
endinterface

// File: rtl/oam_dma_controller.sv
// NES sprite DMA ($4014) sequencer. Passes CPU bus traffic through when idle;
// after a $4014 write it stalls the CPU and copies page $XX00-$XXFF to $2004.
module oam_dma_controller (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      clock_en,
  oam_dma_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam logic [15:0] DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_DATA = 16'h2004;

  state_t      state;
  state_t      state_next;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic        parity;
  logic        trigger;

  // A CPU write to $4014 on an enabled cycle; only acted on while idle.
  assign trigger = clock_en && (bus.cpu_addr == DMA_REG) && !bus.cpu_r_en;

  // State register plus page/index/parity bookkeeping, all gated by clock_en.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      page   <= 8'h00;
      idx    <= 8'h00;
      parity <= 1'b0;
    end else if (clock_en) begin
      parity <= ~parity;
      state  <= state_next;
      if (state == IDLE && trigger) begin
        page <= bus.cpu_w_data;
        idx  <= 8'h00;
      end else if (state == WRITE && idx != 8'hFF) begin
        idx <= idx + 8'd1;
      end
    end
  end

  // Next-state decode; an odd parity in HALT inserts one ALIGN cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (trigger) state_next = HALT;
      HALT:    state_next = parity ? ALIGN : READ;
      ALIGN:   state_next = READ;
      READ:    state_next = WRITE;
      WRITE:   state_next = (idx == 8'hFF) ? IDLE : READ;
      default: state_next = IDLE;
    endcase
  end

  // Bus steering: CPU pass-through when idle, DMA source/destination otherwise.
  always_comb begin
    bus.mem_addr   = bus.cpu_addr;
    bus.mem_r_en   = bus.cpu_r_en;
    bus.mem_w_data = bus.cpu_w_data;
    bus.dma_done   = 1'b0;
    unique case (state)
      IDLE: ;
      HALT, ALIGN, READ: begin
        // HALT/ALIGN issue a dummy read of the first source byte.
        bus.mem_addr = {page, idx};
        bus.mem_r_en = 1'b1;
      end
      WRITE: begin
        // The byte fetched in READ arrives registered from memory this cycle.
        bus.mem_addr   = OAM_DATA;
        bus.mem_r_en   = 1'b0;
        bus.mem_w_data = bus.mem_r_data;
        bus.dma_done   = (idx == 8'hFF) && clock_en;
      end
      default: ;
    endcase
  end

  assign bus.cpu_stall  = (state != IDLE);
  assign bus.dma_active = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_controller.sv
// Scoreboard bench for oam_dma_controller: stimulus pushes the expected bus
// transactions, a negedge monitor pops and compares every logged one.
module tb_oam_dma_controller;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic clock_en = 1'b1;

  oam_dma_if bus ();

  oam_dma_controller dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .clock_en (clock_en),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] ram [0:65535];
  logic [24:0] exp_q [$];
  int n_vec = 0;
  int n_bad = 0;
  int stall_cnt = 0;
  int done_cnt = 0;
  logic par;
  int phase = 0;

  // Memory model: registered read, advancing with the CPU clock enable.
  always @(posedge clock) begin
    if (clock_en) bus.mem_r_data <= ram[bus.mem_addr];
  end

  // Independent parity model: toggles every enabled cycle, cleared by reset.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) par <= 1'b0;
    else if (clock_en) par <= ~par;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every enabled cycle that is a DMA cycle or a memory write.
  always @(negedge clock) begin
    logic [24:0] got;
    logic [24:0] want;
    if (reset_n && clock_en && (bus.cpu_stall || !bus.mem_r_en)) begin
      got = {bus.mem_r_en, bus.mem_addr, bus.mem_r_en ? 8'h00 : bus.mem_w_data};
      if (bus.cpu_stall) stall_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_bus_txn", {7'd0, got}, 32'h0);
      end else begin
        want = exp_q.pop_front();
        chk("bus_txn", {7'd0, got}, {7'd0, want});
      end
    end
    if (reset_n && bus.dma_done) done_cnt++;
  end

  task automatic step(input bit slow);
    @(posedge clock);
    #1;
    if (slow) begin
      phase = (phase + 1) % 3;
      clock_en = (phase == 0);
    end else begin
      clock_en = 1'b1;
    end
  endtask

  task automatic cpu_idle();
    bus.cpu_addr   = 16'h0000;
    bus.cpu_r_en   = 1'b1;
    bus.cpu_w_data = 8'h00;
  endtask

  // want_par: parity value seen in HALT (1 => ALIGN inserted).
  // abort_idx >= 0: assert reset while in WRITE of that index.
  task automatic run_dma(input logic [7:0] pg, input bit want_par, input bit slow,
                         input int abort_idx);
    int e;
    int abort_e;
    int guard;
    bit en_prev;
    bit finished;
    cpu_idle();
    clock_en = 1'b1;
    while (par == want_par) step(1'b0);
    stall_cnt = 0;
    done_cnt  = 0;
    exp_q.push_back({1'b0, 16'h4014, pg});
    exp_q.push_back({1'b1, pg, 8'h00, 8'h00});
    if (want_par) exp_q.push_back({1'b1, pg, 8'h00, 8'h00});
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({1'b1, pg, 8'(i), 8'h00});
      if (abort_idx == i) break;
      exp_q.push_back({1'b0, 16'h2004, ram[{pg, 8'(i)}]});
    end
    bus.cpu_addr   = 16'h4014;
    bus.cpu_r_en   = 1'b0;
    bus.cpu_w_data = pg;
    phase = 0;
    step(slow);
    cpu_idle();
    chk("stall_after_trigger", {31'd0, bus.cpu_stall}, 32'd1);
    e = 0;
    abort_e = 2 + int'(want_par) + 2 * abort_idx;
    finished = 1'b0;
    for (guard = 0; guard < 3000 && !finished; guard++) begin
      en_prev = clock_en;
      step(slow);
      if (en_prev) e++;
      if (abort_idx >= 0 && e == abort_e) begin
        chk("abort_in_write", {15'd0, bus.mem_addr, 1'b0}, {15'd0, 16'h2004, 1'b0});
        bus.cpu_addr   = 16'h1234;
        bus.cpu_r_en   = 1'b1;
        bus.cpu_w_data = 8'h5A;
        reset_n = 1'b0;
        #1;
        chk("abort_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("abort_active", {31'd0, bus.dma_active}, 32'd0);
        chk("abort_done", {31'd0, bus.dma_done}, 32'd0);
        chk("abort_addr", {16'd0, bus.mem_addr}, 32'h1234);
        chk("abort_r_en", {31'd0, bus.mem_r_en}, 32'd1);
        chk("abort_w_data", {24'd0, bus.mem_w_data}, 32'h5A);
        step(1'b0);
        step(1'b0);
        reset_n = 1'b1;
        cpu_idle();
        finished = 1'b1;
      end else if (!bus.cpu_stall) begin
        finished = 1'b1;
      end
    end
    chk("dma_terminated", {31'd0, finished}, 32'd1);
    step(1'b0);
    chk("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    if (abort_idx < 0) begin
      chk("stall_cycles", stall_cnt, 32'(513 + int'(want_par)));
      chk("done_pulses", done_cnt, 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[16'h0200 + i] = 8'(i) ^ 8'hA5;
      ram[16'h0700 + i] = 8'hFF ^ 8'(i);
    end
    cpu_idle();
    bus.cpu_addr = 16'hBEEF;
    bus.cpu_w_data = 8'h3C;
    #12;
    chk("reset_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("reset_active", {31'd0, bus.dma_active}, 32'd0);
    chk("reset_done", {31'd0, bus.dma_done}, 32'd0);
    chk("reset_addr", {16'd0, bus.mem_addr}, 32'hBEEF);
    chk("reset_w_data", {24'd0, bus.mem_w_data}, 32'h3C);
    step(1'b0);
    reset_n = 1'b1;
    step(1'b0);

    // Pass-through: read of $4014, writes to $4015 and $4013.
    bus.cpu_addr = 16'h4014;
    bus.cpu_r_en = 1'b1;
    bus.cpu_w_data = 8'h77;
    #1;
    chk("pt_read_addr", {16'd0, bus.mem_addr}, 32'h4014);
    chk("pt_read_r_en", {31'd0, bus.mem_r_en}, 32'd1);
    step(1'b0);
    chk("pt_read_no_stall", {31'd0, bus.cpu_stall}, 32'd0);
    exp_q.push_back({1'b0, 16'h4015, 8'h11});
    bus.cpu_addr = 16'h4015;
    bus.cpu_r_en = 1'b0;
    bus.cpu_w_data = 8'h11;
    step(1'b0);
    chk("pt_4015_no_stall", {31'd0, bus.cpu_stall}, 32'd0);
    exp_q.push_back({1'b0, 16'h4013, 8'h22});
    bus.cpu_addr = 16'h4013;
    bus.cpu_w_data = 8'h22;
    step(1'b0);
    chk("pt_4013_no_stall", {31'd0, bus.cpu_stall}, 32'd0);
    cpu_idle();
    step(1'b0);
    chk("pt_queue_drained", exp_q.size(), 32'd0);

    run_dma(8'h02, 1'b0, 1'b0, -1);   // even parity
    run_dma(8'h02, 1'b1, 1'b0, -1);   // odd parity, one ALIGN
    run_dma(8'h02, 1'b0, 1'b1, -1);   // clock_en 1-of-3
    run_dma(8'h02, 1'b0, 1'b0, 8'h40);// reset mid-transfer
    run_dma(8'h02, 1'b0, 1'b0, -1);   // fresh transfer after abort
    run_dma(8'h07, 1'b1, 1'b0, -1);   // page $07

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
